operand_fetch: RTL and testbench

- Issue/operand-fetch stage directly upstream of the register file and downstream of instruction fetch.
- Accepts instructions over a valid/ready handshake and drives the register file read selects.
- Absorbs the register file's one-cycle registered read latency and bypasses writeback data the register file cannot yet return.
- Presents fully resolved operands, destination register and decoded immediate to execute over a second valid/ready handshake.

---
 rtl/riscv_pkg.sv | 55 +++++
 rtl/operand_fetch_if.sv | 32 +++
 rtl/operand_fetch_imm_gen.sv | 27 ++
 rtl/operand_fetch.sv | 177 +++++++++++++++++
 tb/tb_operand_fetch.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the operand fetch stage: widths, field
// positions, opcodes and the immediate-format classification.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int RD_LSB     = 7;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;

    localparam logic [OPCODE_W-1:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPCODE_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPCODE_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Map an opcode to the layout its immediate is scattered in.
    function automatic imm_fmt_e imm_format(input logic [OPCODE_W-1:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR: fmt = IMM_I;
            OPCODE_STORE:                            fmt = IMM_S;
            OPCODE_BRANCH:                           fmt = IMM_B;
            OPCODE_LUI, OPCODE_AUIPC:                fmt = IMM_U;
            OPCODE_JAL:                              fmt = IMM_J;
            default:                                 fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    // A writeback matters to a source only when it targets that register
    // and the register is not x0, which always reads as zero.
    function automatic logic wb_hit(input logic enable,
                                    input logic [REG_W-1:0] write_select,
                                    input logic [REG_W-1:0] rs);
        return enable && (write_select == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Upstream (instruction) and downstream (operands to execute) handshakes of
// the operand fetch stage. The stage itself uses the slave view.
interface operand_fetch_if;
    import riscv_pkg::*;

    logic              instr_valid;
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   instr_pc;
    logic              instr_ready;

    logic              op_valid;
    logic              op_ready;
    logic [XLEN-1:0]   op_instr;
    logic [XLEN-1:0]   op_pc;
    logic [XLEN-1:0]   op_rs1_value;
    logic [XLEN-1:0]   op_rs2_value;
    logic [REG_W-1:0]  op_rd;
    logic [XLEN-1:0]   op_imm;

    modport master (
        output instr_valid, instr, instr_pc, op_ready,
        input  instr_ready, op_valid, op_instr, op_pc,
               op_rs1_value, op_rs2_value, op_rd, op_imm
    );

    modport slave (
        input  instr_valid, instr, instr_pc, op_ready,
        output instr_ready, op_valid, op_instr, op_pc,
               op_rs1_value, op_rs2_value, op_rd, op_imm
    );

endinterface

// File: rtl/operand_fetch_imm_gen.sv
// Combinational RV32I immediate decoder: instruction word to sign-extended
// immediate, zero for formats without an immediate.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    imm_fmt_e fmt;

    assign fmt = imm_format(instr[OPCODE_LSB +: OPCODE_W]);

    // Reassemble the immediate bits according to the instruction format.
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage. Slot A waits out the register file's registered read,
// slot B presents resolved operands to execute. Writebacks the register file
// cannot yet return are bypassed into both slots.
module operand_fetch
    import riscv_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    operand_fetch_if.slave    bus,
    output logic [REG_W-1:0]  rf_reg_1_select,
    output logic [REG_W-1:0]  rf_reg_2_select,
    input  logic [XLEN-1:0]   rf_reg_1,
    input  logic [XLEN-1:0]   rf_reg_2,
    input  logic              wb_write_enable,
    input  logic [REG_W-1:0]  wb_write_select,
    input  logic [XLEN-1:0]   wb_data
);

    logic              valid_a;
    logic [XLEN-1:0]   a_instr;
    logic [XLEN-1:0]   a_pc;
    logic              byp1;
    logic              byp2;
    logic [XLEN-1:0]   byp1_data;
    logic [XLEN-1:0]   byp2_data;

    logic              op_valid;
    logic [XLEN-1:0]   op_instr;
    logic [XLEN-1:0]   op_pc;
    logic [XLEN-1:0]   op_rs1_value;
    logic [XLEN-1:0]   op_rs2_value;
    logic [REG_W-1:0]  op_rd;
    logic [XLEN-1:0]   op_imm;

    logic              instr_ready;
    logic              accept;
    logic              a_to_b;
    logic              a_hold;
    logic [REG_W-1:0]  in_rs1;
    logic [REG_W-1:0]  in_rs2;
    logic [REG_W-1:0]  a_rs1;
    logic [REG_W-1:0]  a_rs2;
    logic [REG_W-1:0]  b_rs1;
    logic [REG_W-1:0]  b_rs2;
    logic [REG_W-1:0]  byp_rs1;
    logic [REG_W-1:0]  byp_rs2;
    logic [XLEN-1:0]   a_op1;
    logic [XLEN-1:0]   a_op2;
    logic [XLEN-1:0]   next_op1;
    logic [XLEN-1:0]   next_op2;
    logic [XLEN-1:0]   a_imm;

    assign in_rs1 = bus.instr[RS1_LSB +: REG_W];
    assign in_rs2 = bus.instr[RS2_LSB +: REG_W];
    assign a_rs1  = a_instr[RS1_LSB +: REG_W];
    assign a_rs2  = a_instr[RS2_LSB +: REG_W];
    assign b_rs1  = op_instr[RS1_LSB +: REG_W];
    assign b_rs2  = op_instr[RS2_LSB +: REG_W];

    assign a_to_b      = valid_a && (!op_valid || bus.op_ready);
    assign a_hold      = valid_a && !a_to_b;
    assign instr_ready = !reset && !flush && (!valid_a || a_to_b);
    assign accept      = bus.instr_valid && instr_ready;

    assign byp_rs1 = accept ? in_rs1 : a_rs1;
    assign byp_rs2 = accept ? in_rs2 : a_rs2;

    imm_gen u_imm_gen (
        .instr (a_instr),
        .imm   (a_imm)
    );

    // Point the register file at the incoming instruction when it can be
    // taken, otherwise keep re-reading slot A's sources every edge.
    always_comb begin
        rf_reg_1_select = a_rs1;
        rf_reg_2_select = a_rs2;
        if (instr_ready) begin
            rf_reg_1_select = in_rs1;
            rf_reg_2_select = in_rs2;
        end
    end

    // Slot A's operand is the register file read unless the write at the
    // edge it was read on was caught; the transfer edge's write wins over both.
    always_comb begin
        a_op1    = byp1 ? byp1_data : rf_reg_1;
        a_op2    = byp2 ? byp2_data : rf_reg_2;
        next_op1 = wb_hit(wb_write_enable, wb_write_select, a_rs1) ? wb_data : a_op1;
        next_op2 = wb_hit(wb_write_enable, wb_write_select, a_rs2) ? wb_data : a_op2;
        if (a_rs1 == '0) begin
            next_op1 = '0;
        end
        if (a_rs2 == '0) begin
            next_op2 = '0;
        end
    end

    // Slot A: capture accepted instructions and the writeback seen at the
    // same edge the register file sampled its select.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_a   <= 1'b0;
            a_instr   <= '0;
            a_pc      <= '0;
            byp1      <= 1'b0;
            byp2      <= 1'b0;
            byp1_data <= '0;
            byp2_data <= '0;
        end else if (flush) begin
            valid_a <= 1'b0;
            byp1    <= 1'b0;
            byp2    <= 1'b0;
        end else begin
            if (accept) begin
                valid_a <= 1'b1;
                a_instr <= bus.instr;
                a_pc    <= bus.instr_pc;
            end else if (a_to_b) begin
                valid_a <= 1'b0;
            end
            if (accept || a_hold) begin
                byp1 <= wb_hit(wb_write_enable, wb_write_select, byp_rs1);
                byp2 <= wb_hit(wb_write_enable, wb_write_select, byp_rs2);
            end else begin
                byp1 <= 1'b0;
                byp2 <= 1'b0;
            end
            byp1_data <= wb_data;
            byp2_data <= wb_data;
        end
    end

    // Slot B: load from A when free, otherwise hold while stalled and keep
    // the held source values current with writebacks.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_valid     <= 1'b0;
            op_instr     <= '0;
            op_pc        <= '0;
            op_rs1_value <= '0;
            op_rs2_value <= '0;
            op_rd        <= '0;
            op_imm       <= '0;
        end else if (flush) begin
            op_valid <= 1'b0;
        end else if (a_to_b) begin
            op_valid     <= 1'b1;
            op_instr     <= a_instr;
            op_pc        <= a_pc;
            op_rs1_value <= next_op1;
            op_rs2_value <= next_op2;
            op_rd        <= a_instr[RD_LSB +: REG_W];
            op_imm       <= a_imm;
        end else if (bus.op_ready) begin
            op_valid <= 1'b0;
        end else if (op_valid) begin
            if (wb_hit(wb_write_enable, wb_write_select, b_rs1)) begin
                op_rs1_value <= wb_data;
            end
            if (wb_hit(wb_write_enable, wb_write_select, b_rs2)) begin
                op_rs2_value <= wb_data;
            end
        end
    end

    assign bus.instr_ready  = instr_ready;
    assign bus.op_valid     = op_valid;
    assign bus.op_instr     = op_instr;
    assign bus.op_pc        = op_pc;
    assign bus.op_rs1_value = op_rs1_value;
    assign bus.op_rs2_value = op_rs2_value;
    assign bus.op_rd        = op_rd;
    assign bus.op_imm       = op_imm;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register file model, queue-level reference model
// checked every cycle, and directed scenarios with hand-computed values.
module tb_operand_fetch;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [4:0]  rf_reg_1_select;
    logic [4:0]  rf_reg_2_select;
    logic [31:0] rf_reg_1;
    logic [31:0] rf_reg_2;
    logic        wb_write_enable;
    logic [4:0]  wb_write_select;
    logic [31:0] wb_data;

    operand_fetch_if bus();

    int total = 0;
    int bad   = 0;

    logic [31:0] regs [32];
    logic [31:0] pc_next;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        in_b;
    } item_t;

    item_t mq[$];

    localparam logic [31:0] ADD3  = 32'h002081B3;
    localparam logic [31:0] ADD4  = 32'h00208233;
    localparam logic [31:0] ADD5  = 32'h002082B3;
    localparam logic [31:0] ADDI  = 32'hFFF00093;
    localparam logic [31:0] LUI   = 32'h123452B7;
    localparam logic [31:0] JAL   = 32'hFFDFF0EF;

    operand_fetch dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .bus             (bus),
        .rf_reg_1_select (rf_reg_1_select),
        .rf_reg_2_select (rf_reg_2_select),
        .rf_reg_1        (rf_reg_1),
        .rf_reg_2        (rf_reg_2),
        .wb_write_enable (wb_write_enable),
        .wb_write_select (wb_write_select),
        .wb_data         (wb_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Register file with a one-edge registered read; x0 reads as zero.
    always @(posedge clock) begin
        rf_reg_1 <= (rf_reg_1_select == 5'd0) ? 32'd0 : regs[rf_reg_1_select];
        rf_reg_2 <= (rf_reg_2_select == 5'd0) ? 32'd0 : regs[rf_reg_2_select];
        if (wb_write_enable && wb_write_select != 5'd0) begin
            regs[wb_write_select] <= wb_data;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] model_imm(input logic [31:0] ins);
        logic signed [31:0] s;
        s = $signed(ins);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: return 32'(s >>> 20);
            7'h23: return 32'((s >>> 25) <<< 5) | {27'b0, ins[11:7]};
            7'h63: return 32'((s >>> 31) <<< 12) | {20'b0, ins[7], ins[30:25], ins[11:8], 1'b0};
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6F: return 32'((s >>> 31) <<< 20) | {12'b0, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // The operand an instruction sees is simply the register's current
    // architectural value; x0 is always zero.
    function automatic logic [31:0] model_src(input logic [4:0] rs);
        return (rs == 5'd0) ? 32'd0 : regs[rs];
    endfunction

    // Reference model: a two-entry queue; the head is visible once moved to
    // the output slot; compared against the DUT every cycle.
    initial begin
        logic  exp_ready;
        logic  exp_valid;
        logic  accept;
        logic  fire;
        item_t hd;
        item_t nw;
        forever begin
            @(negedge clock);
            #3;
            exp_ready = !reset && !flush && (mq.size() < 2 || bus.op_ready);
            exp_valid = (mq.size() > 0) && mq[0].in_b;
            check_output("instr_ready", 32'(bus.instr_ready), 32'(exp_ready));
            check_output("op_valid", 32'(bus.op_valid), 32'(exp_valid));
            if (exp_valid) begin
                hd = mq[0];
                check_output("op_instr", bus.op_instr, hd.instr);
                check_output("op_pc", bus.op_pc, hd.pc);
                check_output("op_rd", 32'(bus.op_rd), 32'(hd.instr[11:7]));
                check_output("op_imm", bus.op_imm, model_imm(hd.instr));
                check_output("op_rs1_value", bus.op_rs1_value, model_src(hd.instr[19:15]));
                check_output("op_rs2_value", bus.op_rs2_value, model_src(hd.instr[24:20]));
            end
            if (reset || flush) begin
                mq.delete();
            end else begin
                accept = bus.instr_valid && exp_ready;
                fire   = exp_valid && bus.op_ready;
                if (fire) begin
                    void'(mq.pop_front());
                end
                if (mq.size() > 0 && !mq[0].in_b) begin
                    hd      = mq[0];
                    hd.in_b = 1'b1;
                    mq[0]   = hd;
                end
                if (accept) begin
                    nw.instr = bus.instr;
                    nw.pc    = bus.instr_pc;
                    nw.in_b  = 1'b0;
                    mq.push_back(nw);
                end
            end
        end
    end

    task automatic apply_stimulus(input logic rst, input logic v, input logic [31:0] ins,
                                  input logic rdy, input logic fl, input logic we,
                                  input logic [4:0] ws, input logic [31:0] wd);
        @(negedge clock);
        reset           = rst;
        bus.instr_valid = v;
        bus.instr       = ins;
        bus.instr_pc    = pc_next;
        pc_next         = pc_next + 32'd4;
        bus.op_ready    = rdy;
        flush           = fl;
        wb_write_enable = we;
        wb_write_select = ws;
        wb_data         = wd;
        #2;
    endtask

    initial begin
        logic [31:0] prog [8];
        prog[0] = ADD3;
        prog[1] = 32'h0020A423;
        prog[2] = 32'hFE208CE3;
        prog[3] = 32'hFFC1A303;
        prog[4] = 32'hFFFFF397;
        prog[5] = 32'h00C20067;
        prog[6] = 32'h40418433;
        prog[7] = 32'h0000000F;

        reset           = 1'b1;
        flush           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.instr_pc    = 32'd0;
        bus.op_ready    = 1'b1;
        wb_write_enable = 1'b0;
        wb_write_select = 5'd0;
        wb_data         = 32'd0;
        pc_next         = 32'h0000_1000;

        // Preload the register file through the writeback port under reset.
        for (int i = 1; i < 32; i++) begin
            apply_stimulus(1, 0, 32'd0, 1, 0, 1, 5'(i),
                           (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : (32'h1000_0000 | 32'(i << 8) | 32'(i)));
        end
        apply_stimulus(1, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("reset_op_valid", 32'(bus.op_valid), 32'd0);
        check_output("reset_instr_ready", 32'(bus.instr_ready), 32'd0);
        check_output("reset_op_instr", bus.op_instr, 32'd0);
        check_output("reset_op_rs1", bus.op_rs1_value, 32'd0);
        check_output("reset_op_imm", bus.op_imm, 32'd0);
        check_output("reset_sel1", 32'(rf_reg_1_select), 32'd0);
        check_output("reset_sel2", 32'(rf_reg_2_select), 32'd0);

        $display("[TB] back-to-back adds");
        apply_stimulus(0, 1, ADD3, 1, 0, 0, 5'd0, 32'd0);
        check_output("ready_empty", 32'(bus.instr_ready), 32'd1);
        apply_stimulus(0, 1, ADD4, 1, 0, 0, 5'd0, 32'd0);
        check_output("latency_not_yet", 32'(bus.op_valid), 32'd0);
        apply_stimulus(0, 1, ADD5, 1, 0, 0, 5'd0, 32'd0);
        check_output("add_valid", 32'(bus.op_valid), 32'd1);
        check_output("add_rs1", bus.op_rs1_value, 32'd5);
        check_output("add_rs2", bus.op_rs2_value, 32'd7);
        check_output("add_rd", 32'(bus.op_rd), 32'd3);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("b2b_rd4", 32'(bus.op_rd), 32'd4);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("b2b_rd5", 32'(bus.op_rd), 32'd5);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("b2b_drained", 32'(bus.op_valid), 32'd0);

        $display("[TB] writeback on accept edge");
        apply_stimulus(0, 1, ADD3, 1, 0, 1, 5'd1, 32'h55);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("accept_wb_rs1", bus.op_rs1_value, 32'h55);
        check_output("accept_wb_rs2", bus.op_rs2_value, 32'd7);

        $display("[TB] writeback on transfer edge and during stall");
        apply_stimulus(0, 1, ADD3, 0, 0, 0, 5'd0, 32'd0);
        apply_stimulus(0, 0, 32'd0, 0, 0, 1, 5'd2, 32'h99);
        apply_stimulus(0, 1, ADD4, 0, 0, 0, 5'd0, 32'd0);
        check_output("xfer_wb_rs2", bus.op_rs2_value, 32'h99);
        check_output("xfer_rs1", bus.op_rs1_value, 32'h55);
        check_output("stall_ready_a_empty", 32'(bus.instr_ready), 32'd1);
        apply_stimulus(0, 0, 32'd0, 0, 0, 1, 5'd1, 32'h77);
        check_output("stall_ready_full", 32'(bus.instr_ready), 32'd0);
        check_output("stall_rs1_before", bus.op_rs1_value, 32'h55);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("stall_rs1_after", bus.op_rs1_value, 32'h77);
        check_output("stall_rs2_kept", bus.op_rs2_value, 32'h99);
        check_output("stall_rd_kept", 32'(bus.op_rd), 32'd3);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("slot_a_bypass_rd", 32'(bus.op_rd), 32'd4);
        check_output("slot_a_bypass_rs1", bus.op_rs1_value, 32'h77);

        $display("[TB] x0 source");
        apply_stimulus(0, 1, ADDI, 1, 0, 1, 5'd0, 32'hFFFF_FFFF);
        apply_stimulus(0, 0, 32'd0, 1, 0, 1, 5'd0, 32'hFFFF_FFFF);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("x0_rs1", bus.op_rs1_value, 32'd0);
        check_output("addi_imm", bus.op_imm, 32'hFFFF_FFFF);

        $display("[TB] immediate decode");
        apply_stimulus(0, 1, LUI, 1, 0, 0, 5'd0, 32'd0);
        apply_stimulus(0, 1, JAL, 1, 0, 0, 5'd0, 32'd0);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("lui_imm", bus.op_imm, 32'h1234_5000);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("jal_imm", bus.op_imm, 32'hFFFF_FFFC);

        $display("[TB] flush with both slots full");
        apply_stimulus(0, 1, ADD3, 0, 0, 0, 5'd0, 32'd0);
        apply_stimulus(0, 1, ADD4, 0, 0, 0, 5'd0, 32'd0);
        apply_stimulus(0, 1, ADD5, 0, 1, 0, 5'd0, 32'd0);
        check_output("flush_ready", 32'(bus.instr_ready), 32'd0);
        apply_stimulus(0, 1, ADD5, 1, 0, 0, 5'd0, 32'd0);
        check_output("flush_cleared", 32'(bus.op_valid), 32'd0);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("post_flush_rd", 32'(bus.op_rd), 32'd5);
        check_output("post_flush_rs1", bus.op_rs1_value, 32'h77);
        check_output("post_flush_rs2", bus.op_rs2_value, 32'h99);

        $display("[TB] reset mid-stream");
        apply_stimulus(0, 1, ADD3, 0, 0, 0, 5'd0, 32'd0);
        apply_stimulus(0, 1, ADD4, 0, 0, 0, 5'd0, 32'd0);
        apply_stimulus(1, 1, ADD5, 0, 0, 0, 5'd0, 32'd0);
        check_output("midreset_ready", 32'(bus.instr_ready), 32'd0);
        apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        check_output("midreset_valid", 32'(bus.op_valid), 32'd0);
        check_output("midreset_instr", bus.op_instr, 32'd0);
        check_output("midreset_pc", bus.op_pc, 32'd0);
        check_output("midreset_rs1", bus.op_rs1_value, 32'd0);
        check_output("midreset_rs2", bus.op_rs2_value, 32'd0);
        check_output("midreset_rd", 32'(bus.op_rd), 32'd0);
        check_output("midreset_imm", bus.op_imm, 32'd0);
        check_output("midreset_sel1", 32'(rf_reg_1_select), 32'd0);

        $display("[TB] mixed burst");
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(0, (i % 4) != 3, prog[i % 8], (i % 3) != 1, 0,
                           (i % 2) == 1, 5'((i % 5) + 1), 32'hA000_0000 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
        end
        check_output("burst_drained", 32'(bus.op_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
